sib_auth_ctrl: RTL
==================

Name: sib_auth_ctrl

Overview:
Challenge-response authenticator that consumes the 32-bit pseudo-random word from the LFSR stage. It is the gate for the secure segment-insertion bit (SIB) on the IJTAG network. On capture-DR it freezes the LFSR word as a challenge and shifts it out on TDO while the tester shifts a response in on TDI. On update-DR it compares the response against challenge XOR key and drives the unlock that admits the protected instrument segment into the scan path.

Parameters:
WIDTH, 32, challenge/response width; must equal the LFSR width.
AUTH_KEY, 32'hA5C3_1E7D, secret XOR key; expected response = challenge ^ AUTH_KEY.
MAX_FAIL, 3, consecutive failed attempts before permanent lockout (range 1..15).
TIMEOUT, 1024, cycles an unlock remains valid (used only with the optional feature).

Ports:
clk  in  1  system/TCK-domain clock, rising edge.
reset_n  in  1  asynchronous active-low reset.
challenge_in  in  WIDTH  current LFSR word.
capture_en  in  1  capture-DR strobe, 1-cycle pulse.
shift_en  in  1  shift-DR qualifier, one bit per cycle while high.
update_en  in  1  update-DR strobe, 1-cycle pulse.
tdi  in  1  serial response in.
tdo  out  1  serial challenge out, LSB first.
unlocked  out  1  high while access is granted; drives the SIB select.
lockout  out  1  sticky; high after MAX_FAIL consecutive failures.
fail_cnt  out  4  consecutive failure count.

Behaviour:
- Reset (async assert, sync release): state=IDLE; shift register, challenge latch, bit counter = 0; tdo=0, unlocked=0, lockout=0, fail_cnt=0.
- States:
  - IDLE: capture_en -> CAPTURE.
  - CAPTURE: 1 cycle. Latch challenge_in into both chal_q and sreg; clear bit counter. -> SHIFT.
  - SHIFT:
    - Each cycle with shift_en=1: sreg <= {tdi, sreg[WIDTH-1:1]}; tdo = sreg[0] (combinational); bit counter increments and saturates at WIDTH.
    - update_en -> COMPARE.
    - capture_en -> CAPTURE (restart; counter cleared).
  - COMPARE: 1 cycle.
    - Pass: bit counter == WIDTH exactly and sreg == chal_q ^ AUTH_KEY. Action: unlocked<=1, fail_cnt<=0, -> UNLOCKED.
    - Otherwise fail: fail_cnt<=fail_cnt+1. If the new count == MAX_FAIL: lockout<=1, -> LOCKOUT. Else -> IDLE.
  - UNLOCKED: unlocked held high. A new capture_en clears unlocked in the same cycle and -> CAPTURE (re-authentication required).
  - LOCKOUT: terminal until reset_n. All strobes ignored; tdo=0; unlocked=0.
- tdo is 0 outside SHIFT.
- An underlength or overlength shift (counter != WIDTH at update) always fails, even if sreg matches.
- Strobe priority when simultaneous: capture_en > update_en > shift_en. In SHIFT, capture_en and update_en in the same cycle -> CAPTURE, with no failure counted.
- update_en in IDLE or UNLOCKED: ignored.
- challenge_in is sampled only in CAPTURE; LFSR changes during SHIFT have no effect.
- Latency: unlocked rises 2 cycles after the update_en cycle (COMPARE, then register).
- reset_n asserted mid-shift: immediate return to reset values; a partial response is discarded and not counted as a failure.

Optional Feature:
Macro SIB_AUTH_TIMEOUT_EN.
- Defined: a 16-bit timer loads TIMEOUT on entry to UNLOCKED and decrements each cycle. At 0: unlocked<=0, -> IDLE, fail_cnt unchanged.
- Undefined: no timer; unlocked persists until the next capture_en or reset.

Decomposition:
- Shared package sib_auth_pkg: state enum (IDLE, CAPTURE, SHIFT, COMPARE, UNLOCKED, LOCKOUT), WIDTH default, AUTH_KEY default, fail counter width constant.
- One sub-module, sib_auth_shreg: WIDTH-bit capture/shift register with parallel load, serial in/out and saturating bit counter. The FSM stays in the top module.

Test Plan:
- Correct response: challenge_in=32'h0000_00FF, capture, shift 32 bits of 32'hA5C3_1E82, update -> unlocked=1 two cycles after update; tdo stream is 0xFF LSB-first, then zeros.
- Wrong response: same challenge, shift 32'h0 -> unlocked=0, fail_cnt=1, state IDLE. Repeat to 3 failures -> lockout=1; a further correct attempt is still refused.
- Length check: correct value but only 31 or 33 shift cycles -> fail, fail_cnt increments.
- Challenge stability: challenge_in toggled every cycle during SHIFT -> result judged against the word captured in CAPTURE.
- Reset mid-shift: assert reset_n=0 after 10 shift cycles -> all outputs 0 immediately, fail_cnt=0. A following full correct sequence unlocks.
- SIB_AUTH_TIMEOUT_EN with TIMEOUT=16: after unlock, unlocked falls exactly 16 cycles later. Without the macro: unlocked stays high for 1000 cycles, then drops at the next capture_en.

Source files
------------

// File: rtl/sib_auth_pkg.sv
// Shared definitions for the secure-SIB challenge-response authenticator.
//
// Contents:
//   SibWidth   - default challenge/response width (matches the LFSR stage)
//   SibAuthKey - default secret XOR key
//   FailCntW   - width of the consecutive-failure counter
//   sib_state_e - controller state encoding
package sib_auth_pkg;

  localparam int unsigned SibWidth   = 32;
  localparam logic [31:0] SibAuthKey = 32'hA5C3_1E7D;
  localparam int unsigned FailCntW   = 4;

  typedef enum logic [2:0] {
    StIdle,
    StCapture,
    StShift,
    StCompare,
    StUnlocked,
    StLockout
  } sib_state_e;

endpackage

// File: rtl/sib_auth_shreg.sv
// Capture/shift register for the authenticator data register.
//
// Parallel-loads the challenge, then shifts right one bit per enabled cycle with the
// response entering at the MSB, so the challenge leaves LSB first on sdo_o. A bit
// counter saturates at WIDTH; over_o flags any shift made after the counter saturated,
// so an overlength shift can be told apart from an exact-length one.
//
// Ports:
//   clk_i       - clock, rising edge
//   rst_ni      - asynchronous active-low reset
//   load_i      - parallel load of load_data_i; clears counter and overflow flag
//   load_data_i - word to load
//   shift_i     - shift one bit (ignored while load_i is high)
//   sdi_i       - serial data in (enters at MSB)
//   sdo_o       - serial data out (current LSB)
//   data_o      - register contents
//   cnt_o       - number of bits shifted since load, saturating at WIDTH
//   over_o      - at least one bit was shifted beyond WIDTH
module sib_auth_shreg #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CntW  = $clog2(WIDTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_data_i,
  input  logic             shift_i,
  input  logic             sdi_i,
  output logic             sdo_o,
  output logic [WIDTH-1:0] data_o,
  output logic [CntW-1:0]  cnt_o,
  output logic             over_o
);

  logic [WIDTH-1:0] data_q, data_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             over_q, over_d;

  always_comb begin
    data_d = data_q;
    cnt_d  = cnt_q;
    over_d = over_q;
    if (load_i) begin
      data_d = load_data_i;
      cnt_d  = '0;
      over_d = 1'b0;
    end else if (shift_i) begin
      data_d = {sdi_i, data_q[WIDTH-1:1]};
      if (cnt_q == CntW'(WIDTH)) begin
        over_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= '0;
      cnt_q  <= '0;
      over_q <= 1'b0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
      over_q <= over_d;
    end
  end

  assign sdo_o  = data_q[0];
  assign data_o = data_q;
  assign cnt_o  = cnt_q;
  assign over_o = over_q;

endmodule

// File: rtl/sib_auth_ctrl.sv
// Challenge-response gate for the secure segment-insertion bit on the IJTAG network.
//
// On capture-DR the current LFSR word is frozen as the challenge and shifted out on tdo
// while the tester shifts a response in on tdi. On update-DR the response is checked
// against challenge ^ AUTH_KEY; a match with exactly WIDTH shifted bits raises unlocked.
// MAX_FAIL consecutive failures lock the block out until reset.
//
// Optional feature (macro SIB_AUTH_TIMEOUT_EN): when defined, an unlock expires
// TIMEOUT cycles after it is granted. When undefined, unlocked persists until the next
// capture_en or reset.
//
// Ports:
//   clk          - TCK-domain clock, rising edge
//   reset_n      - asynchronous active-low reset
//   challenge_in - current LFSR word
//   capture_en   - capture-DR strobe
//   shift_en     - shift-DR qualifier, one bit per cycle
//   update_en    - update-DR strobe
//   tdi          - serial response in
//   tdo          - serial challenge out, LSB first; 0 outside the shift phase
//   unlocked     - access granted (drives the SIB select)
//   lockout      - sticky permanent lockout
//   fail_cnt     - consecutive failure count
module sib_auth_ctrl
  import sib_auth_pkg::*;
#(
  parameter int unsigned     WIDTH    = SibWidth,
  parameter logic [WIDTH-1:0] AUTH_KEY = WIDTH'(SibAuthKey),
  parameter int unsigned     MAX_FAIL = 3,
  parameter int unsigned     TIMEOUT  = 1024
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [WIDTH-1:0]    challenge_in,
  input  logic                capture_en,
  input  logic                shift_en,
  input  logic                update_en,
  input  logic                tdi,
  output logic                tdo,
  output logic                unlocked,
  output logic                lockout,
  output logic [FailCntW-1:0] fail_cnt
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  // Elaboration-time parameter range checks.
  if (MAX_FAIL < 1 || MAX_FAIL > 15) begin : g_bad_max_fail
    $error("sib_auth_ctrl: MAX_FAIL must be in 1..15");
  end
  if (TIMEOUT > 65535) begin : g_bad_timeout
    $error("sib_auth_ctrl: TIMEOUT must fit in 16 bits");
  end

  sib_state_e          state_q;
  logic [WIDTH-1:0]    chal_q;
  logic                unlocked_q;
  logic                lockout_q;
  logic [FailCntW-1:0] fail_cnt_q;
`ifdef SIB_AUTH_TIMEOUT_EN
  logic [15:0]         timer_q;
`endif

  logic                sreg_load;
  logic                sreg_shift;
  logic                sreg_sdo;
  logic [WIDTH-1:0]    sreg_data;
  logic [CntW-1:0]     bit_cnt;
  logic                bit_over;
  logic                resp_ok;
  logic [FailCntW-1:0] fail_cnt_inc;

  // capture_en and update_en both outrank shift_en, so a strobe cycle never shifts.
  always_comb begin
    sreg_load    = (state_q == StCapture);
    sreg_shift   = (state_q == StShift) && shift_en && !capture_en && !update_en;
    resp_ok      = (bit_cnt == CntW'(WIDTH)) && !bit_over &&
                   (sreg_data == (chal_q ^ AUTH_KEY));
    fail_cnt_inc = fail_cnt_q + FailCntW'(1);
  end

  sib_auth_shreg #(
    .WIDTH (WIDTH),
    .CntW  (CntW)
  ) u_shreg (
    .clk_i       (clk),
    .rst_ni      (reset_n),
    .load_i      (sreg_load),
    .load_data_i (challenge_in),
    .shift_i     (sreg_shift),
    .sdi_i       (tdi),
    .sdo_o       (sreg_sdo),
    .data_o      (sreg_data),
    .cnt_o       (bit_cnt),
    .over_o      (bit_over)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      chal_q     <= '0;
      unlocked_q <= 1'b0;
      lockout_q  <= 1'b0;
      fail_cnt_q <= '0;
`ifdef SIB_AUTH_TIMEOUT_EN
      timer_q    <= '0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (capture_en) begin
            state_q <= StCapture;
          end
        end
        StCapture: begin
          // The shift register loads the same word this cycle.
          chal_q  <= challenge_in;
          state_q <= StShift;
        end
        StShift: begin
          // A restart (capture_en) wins over update_en and counts as no attempt.
          if (capture_en) begin
            state_q <= StCapture;
          end else if (update_en) begin
            state_q <= StCompare;
          end
        end
        StCompare: begin
          if (resp_ok) begin
            unlocked_q <= 1'b1;
            fail_cnt_q <= '0;
            state_q    <= StUnlocked;
`ifdef SIB_AUTH_TIMEOUT_EN
            timer_q    <= 16'(TIMEOUT);
`endif
          end else begin
            fail_cnt_q <= fail_cnt_inc;
            if (fail_cnt_inc == FailCntW'(MAX_FAIL)) begin
              lockout_q <= 1'b1;
              state_q   <= StLockout;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        StUnlocked: begin
          if (capture_en) begin
            unlocked_q <= 1'b0;
            state_q    <= StCapture;
          end
`ifdef SIB_AUTH_TIMEOUT_EN
          // Expire on the last counted cycle so unlocked stays high exactly TIMEOUT cycles.
          else if (timer_q <= 16'd1) begin
            unlocked_q <= 1'b0;
            state_q    <= StIdle;
          end else begin
            timer_q <= timer_q - 16'd1;
          end
`endif
        end
        StLockout: begin
          state_q <= StLockout;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign tdo      = (state_q == StShift) ? sreg_sdo : 1'b0;
  assign unlocked = unlocked_q;
  assign lockout  = lockout_q;
  assign fail_cnt = fail_cnt_q;

endmodule
